// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl -- march-style BIST controller for a 16x8 synchronous RAM.
//
// A run writes PATTERN to every address in ascending order and reads it back,
// then writes ~PATTERN in descending order and reads it back. Each read phase
// ends with one drain cycle so the last read word can still be compared.
//
// Optional feature (macro RAM_BIST_ERRCNT_EN):
//   defined   : the run always completes all four phases; err_count counts
//               every miscompare, saturating at 31.
//   undefined : the first miscompare forces DONE on the next cycle.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   start        begin a run (sampled only in IDLE)
//   ram_addr     RAM address
//   ram_datain   RAM write data
//   ram_write    RAM write strobe
//   ram_read     RAM read strobe (data valid on ram_dataout one cycle later)
//   ram_dataout  RAM read data
//   busy         high while a test phase is running
//   done         one-cycle pulse on entry to DONE
//   pass         result, valid from done until the next accepted start
//   fail_addr    address of the first miscompare
//   err_count    number of miscompares
module ram_bist_ctrl #(
    parameter logic [7:0] PATTERN = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_datain,
    output logic       ram_write,
    output logic       ram_read,
    input  logic [7:0] ram_dataout,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_addr,
    output logic [4:0] err_count
);

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        RD0,
        WR1,
        RD1,
        DONE
    } state_t;

    state_t     state, state_next;
    logic [3:0] addr, addr_next;
    logic       drain, drain_next;
    logic       accept;

    // Compare pipeline: the word read in cycle t is checked in cycle t+1.
    logic       cmp_valid;
    logic [3:0] cmp_addr;
    logic [7:0] cmp_exp;
    logic       mismatch;

    always_comb begin
        state_next = state;
        addr_next  = addr;
        drain_next = drain;
        accept     = 1'b0;
        ram_write  = 1'b0;
        ram_read   = 1'b0;
        ram_datain = '0;
        busy       = 1'b0;
        done       = 1'b0;

        // Compares only happen inside read phases (the drain cycle included),
        // so a read still in flight when DONE is forced is ignored.
        cmp_exp  = (state == RD1) ? ~PATTERN : PATTERN;
        mismatch = cmp_valid && ((state == RD0) || (state == RD1)) &&
                   (ram_dataout != cmp_exp);

        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = WR0;
                    addr_next  = '0;
                    drain_next = 1'b0;
                end
            end
            WR0: begin
                busy       = 1'b1;
                ram_write  = 1'b1;
                ram_datain = PATTERN;
                if (addr == 4'd15) begin
                    state_next = RD0;
                    addr_next  = '0;
                end else begin
                    addr_next = addr + 4'd1;
                end
            end
            RD0: begin
                busy = 1'b1;
                if (drain) begin
                    state_next = WR1;
                    addr_next  = 4'd15;
                    drain_next = 1'b0;
                end else begin
                    ram_read = 1'b1;
                    if (addr == 4'd15) drain_next = 1'b1;
                    else               addr_next  = addr + 4'd1;
                end
            end
            WR1: begin
                busy       = 1'b1;
                ram_write  = 1'b1;
                ram_datain = ~PATTERN;
                if (addr == 4'd0) begin
                    state_next = RD1;
                    addr_next  = 4'd15;
                end else begin
                    addr_next = addr - 4'd1;
                end
            end
            RD1: begin
                busy = 1'b1;
                if (drain) begin
                    state_next = DONE;
                    drain_next = 1'b0;
                end else begin
                    ram_read = 1'b1;
                    if (addr == 4'd0) drain_next = 1'b1;
                    else              addr_next  = addr - 4'd1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

`ifndef RAM_BIST_ERRCNT_EN
        if (mismatch) begin
            state_next = DONE;
            drain_next = 1'b0;
        end
`endif
    end

    assign ram_addr = addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            addr  <= '0;
            drain <= 1'b0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            drain <= drain_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_valid <= 1'b0;
            cmp_addr  <= '0;
        end else begin
            cmp_valid <= ram_read;
            cmp_addr  <= addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass      <= 1'b0;
            fail_addr <= '0;
            err_count <= '0;
        end else if (accept) begin
            pass      <= 1'b0;
            fail_addr <= '0;
            err_count <= '0;
        end else begin
            if (mismatch) begin
                if (err_count == 5'd0)  fail_addr <= cmp_addr;
                if (err_count != 5'd31) err_count <= err_count + 5'd1;
            end
            // A miscompare in the final drain cycle lands in the same cycle
            // as the DONE transition, so it must be folded in here.
            if ((state_next == DONE) && (state != DONE))
                pass <= !mismatch && (err_count == 5'd0);
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl -- directed self-checking bench for ram_bist_ctrl.
// Includes a 16x8 RAM model with per-address stuck-at-0/1 bit masks.
module tb_ram_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] ram_addr;
    logic [7:0] ram_datain;
    logic       ram_write;
    logic       ram_read;
    logic [7:0] ram_dataout;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_addr;
    logic [4:0] err_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [16];
    logic [7:0] sa0 [16];
    logic [7:0] sa1 [16];

    logic [3:0] wr_addr_log [$];
    logic [7:0] wr_data_log [$];
    logic [3:0] rd_addr_log [$];

    ram_bist_ctrl #(.PATTERN(8'h55)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ram_addr    (ram_addr),
        .ram_datain  (ram_datain),
        .ram_write   (ram_write),
        .ram_read    (ram_read),
        .ram_dataout (ram_dataout),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_addr   (fail_addr),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, one-cycle read latency, stuck-at faults on read.
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_datain;
        if (ram_read)  ram_dataout <= (mem[ram_addr] | sa1[ram_addr]) & ~sa0[ram_addr];
    end

    // Strobe exclusivity and transaction logging.
    always @(negedge clk) begin
        checks++;
        if (ram_read && ram_write) begin
            errors++;
            $display("FAIL rw_exclusive: ram_read=%0b ram_write=%0b at %0t, required not both 1",
                     ram_read, ram_write, $time);
        end
        if (ram_write) begin
            wr_addr_log.push_back(ram_addr);
            wr_data_log.push_back(ram_datain);
        end
        if (ram_read) rd_addr_log.push_back(ram_addr);
    end

    task automatic clear_faults();
        for (int i = 0; i < 16; i++) begin
            sa0[i] = 8'h00;
            sa1[i] = 8'h00;
            mem[i] = 8'h00;
        end
    endtask

    // Pulses start, counts busy cycles until done; reports done pulse width.
    task automatic run_bist(output int bc, output int dw, output bit to);
        int n;
        bc = 0; dw = 0; to = 1'b0; n = 0;
        @(negedge clk);
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && n < 200) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            to = 1'b1;
        end else begin
            while (done && dw < 3) begin
                dw++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ram_addr, ram_datain, ram_write, ram_read, busy, done, pass, fail_addr, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%h din=%h wr=%b rd=%b busy=%b done=%b pass=%b fa=%h ec=%0d, required all 0",
                     ram_addr, ram_datain, ram_write, ram_read, busy, done, pass, fail_addr, err_count);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_pass_run();
        int bc, dw;
        bit to;
        clear_faults();
        run_bist(bc, dw, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL pass_timeout: done not seen within 200 cycles, required done");
        end
        checks++;
        if (bc !== 66) begin
            errors++;
            $display("FAIL pass_busy_cycles: got %0d, required 66", bc);
        end
        checks++;
        if (dw !== 1) begin
            errors++;
            $display("FAIL pass_done_width: got %0d, required 1", dw);
        end
        checks++;
        if (pass !== 1'b1 || err_count !== 5'd0) begin
            errors++;
            $display("FAIL pass_result: pass=%b err_count=%0d, required pass=1 err_count=0", pass, err_count);
        end
        checks++;
        if (wr_addr_log.size() !== 32 || rd_addr_log.size() !== 32) begin
            errors++;
            $display("FAIL pass_txn_count: writes=%0d reads=%0d, required 32 and 32",
                     wr_addr_log.size(), rd_addr_log.size());
        end else begin
            for (int i = 0; i < 32; i++) begin
                logic [3:0] ea;
                logic [7:0] ed;
                ea = (i < 16) ? 4'(i) : 4'(31 - i);
                ed = (i < 16) ? 8'h55 : 8'hAA;
                checks++;
                if (wr_addr_log[i] !== ea || wr_data_log[i] !== ed) begin
                    errors++;
                    $display("FAIL pass_write_seq[%0d]: addr=%h data=%h, required addr=%h data=%h",
                             i, wr_addr_log[i], wr_data_log[i], ea, ed);
                end
                checks++;
                if (rd_addr_log[i] !== ea) begin
                    errors++;
                    $display("FAIL pass_read_seq[%0d]: addr=%h, required %h", i, rd_addr_log[i], ea);
                end
            end
        end
    endtask

    task automatic test_stuck1_addr4();
        int bc, dw;
        bit to;
        int exp_bc;
`ifdef RAM_BIST_ERRCNT_EN
        exp_bc = 66;
`else
        exp_bc = 62;
`endif
        clear_faults();
        sa1[4] = 8'h01;
        run_bist(bc, dw, to);
        checks++;
        if (to || bc !== exp_bc) begin
            errors++;
            $display("FAIL sa1_busy_cycles: got %0d (timeout=%0b), required %0d", bc, to, exp_bc);
        end
        checks++;
        if (pass !== 1'b0 || fail_addr !== 4'd4 || err_count !== 5'd1) begin
            errors++;
            $display("FAIL sa1_result: pass=%b fail_addr=%0d err_count=%0d, required 0/4/1",
                     pass, fail_addr, err_count);
        end
        checks++;
        if (wr_addr_log.size() !== 32) begin
            errors++;
            $display("FAIL sa1_write_count: got %0d, required 32", wr_addr_log.size());
        end
    endtask

    task automatic test_stuck0_addr9();
        int bc, dw;
        bit to;
        clear_faults();
        sa0[9] = 8'h01;
`ifdef RAM_BIST_ERRCNT_EN
        sa1[4] = 8'h01;
        run_bist(bc, dw, to);
        checks++;
        if (to || bc !== 66) begin
            errors++;
            $display("FAIL two_fault_busy_cycles: got %0d (timeout=%0b), required 66", bc, to);
        end
        checks++;
        if (pass !== 1'b0 || fail_addr !== 4'd9 || err_count !== 5'd2) begin
            errors++;
            $display("FAIL two_fault_result: pass=%b fail_addr=%0d err_count=%0d, required 0/9/2",
                     pass, fail_addr, err_count);
        end
`else
        run_bist(bc, dw, to);
        checks++;
        if (to || bc !== 27) begin
            errors++;
            $display("FAIL early_done_busy_cycles: got %0d (timeout=%0b), required 27", bc, to);
        end
        checks++;
        if (dw !== 1) begin
            errors++;
            $display("FAIL early_done_width: got %0d, required 1", dw);
        end
        checks++;
        if (pass !== 1'b0 || fail_addr !== 4'd9 || err_count !== 5'd1) begin
            errors++;
            $display("FAIL early_done_result: pass=%b fail_addr=%0d err_count=%0d, required 0/9/1",
                     pass, fail_addr, err_count);
        end
        checks++;
        if (wr_addr_log.size() !== 16) begin
            errors++;
            $display("FAIL early_done_no_wr1: writes=%0d, required 16", wr_addr_log.size());
        end
`endif
    endtask

    task automatic test_reset_midrun();
        int bc, dw, n;
        bit to, saw_done;
        clear_faults();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_busy_before_reset: busy=%b, required 1", busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ram_addr, ram_datain, ram_write, ram_read, busy, done, pass, fail_addr, err_count} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs: addr=%h din=%h wr=%b rd=%b busy=%b done=%b pass=%b fa=%h ec=%0d, required all 0",
                     ram_addr, ram_datain, ram_write, ram_read, busy, done, pass, fail_addr, err_count);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midrun_no_done: done or busy seen after abort, required neither");
        end
        run_bist(bc, dw, to);
        checks++;
        if (to || bc !== 66 || dw !== 1 || pass !== 1'b1 || err_count !== 5'd0) begin
            errors++;
            $display("FAIL midrun_restart: busy=%0d done_w=%0d pass=%b ec=%0d to=%b, required 66/1/1/0/0",
                     bc, dw, pass, err_count, to);
        end
    endtask

    task automatic test_start_held();
        int bc, n;
        clear_faults();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        bc = 0; n = 0;
        while (!done && n < 200) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200 || bc !== 66 || pass !== 1'b1) begin
            errors++;
            $display("FAIL held_first_run: busy=%0d pass=%b n=%0d, required 66 busy and pass=1", bc, pass, n);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL held_idle_gap: busy=%b done=%b, required 0/0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_second_start: busy=%b, required 1", busy);
        end
        start = 1'b0;
        bc = 0; n = 0;
        while (!done && n < 200) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200 || bc !== 66 || pass !== 1'b1) begin
            errors++;
            $display("FAIL held_second_run: busy=%0d pass=%b n=%0d, required 66 busy and pass=1", bc, pass, n);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_no_rerun: busy=%b, required 0", busy);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        clear_faults();
        test_reset();
        test_pass_run();
        test_stuck1_addr4();
        test_stuck0_addr9();
        test_reset_midrun();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
